// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter that owns the select lines of a shared 8-to-1 bit mux.
// Grants are held until done, request drop, or MAX_HOLD cycles; the selected bit is registered.
module mux8_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  input  logic [7:0] A,
  output logic [2:0] sel,
  output logic [7:0] gnt,
  output logic       busy,
  output logic       data_out,
  output logic       timeout
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     state_r;
  state_t     state_next_s;
  logic [2:0] ptr_r;
  logic [2:0] ptr_next_s;
  logic [2:0] sel_r;
  logic [2:0] sel_next_s;
  logic [7:0] cnt_r;
  logic [7:0] cnt_next_s;
  logic [7:0] gnt_r;
  logic [7:0] gnt_next_s;
  logic       busy_r;
  logic       busy_next_s;
  logic       data_r;
  logic       data_next_s;
  logic       timeout_r;
  logic       timeout_next_s;
  logic [2:0] win_s;
  logic       win_found_s;
  logic       hold_end_s;
  logic       release_s;

  assign hold_end_s = (cnt_r == HOLD_LAST);
  assign release_s  = done | ~req[sel_r] | hold_end_s;

  // Winner search: first requester at or after ptr, wrapping 7 -> 0
  always_comb begin
    win_s       = 3'd0;
    win_found_s = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (!win_found_s && req[ptr_r + 3'(k)]) begin
        win_s       = ptr_r + 3'(k);
        win_found_s = 1'b1;
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:    state_next_s = (req != 8'h00) ? GRANT : IDLE;
      GRANT:   state_next_s = release_s ? IDLE : GRANT;
      default: state_next_s = IDLE;
    endcase
  end

  // Output logic: next values for every registered output and for ptr/cnt
  always_comb begin
    sel_next_s     = sel_r;
    gnt_next_s     = 8'h00;
    busy_next_s    = 1'b0;
    data_next_s    = 1'b0;
    timeout_next_s = 1'b0;
    ptr_next_s     = ptr_r;
    cnt_next_s     = 8'd0;
    case (state_r)
      IDLE: begin
        if (req != 8'h00) begin
          sel_next_s  = win_s;
          gnt_next_s  = 8'd1 << win_s;
          busy_next_s = 1'b1;
        end else begin
          sel_next_s  = sel_r;
        end
      end
      GRANT: begin
        data_next_s = A[sel_r];
        if (release_s) begin
          ptr_next_s     = sel_r + 3'd1;
          // done or a dropped request wins over the hold limit: no timeout pulse
          timeout_next_s = hold_end_s & ~done & req[sel_r];
        end else begin
          gnt_next_s  = gnt_r;
          busy_next_s = 1'b1;
          cnt_next_s  = cnt_r + 8'd1;
        end
      end
      default: begin
        gnt_next_s = 8'h00;
      end
    endcase
  end

  // Output, pointer and hold-counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_r     <= 3'd0;
      gnt_r     <= 8'h00;
      busy_r    <= 1'b0;
      data_r    <= 1'b0;
      timeout_r <= 1'b0;
      ptr_r     <= 3'd0;
      cnt_r     <= 8'd0;
    end else begin
      sel_r     <= sel_next_s;
      gnt_r     <= gnt_next_s;
      busy_r    <= busy_next_s;
      data_r    <= data_next_s;
      timeout_r <= timeout_next_s;
      ptr_r     <= ptr_next_s;
      cnt_r     <= cnt_next_s;
    end
  end

  assign sel      = sel_r;
  assign gnt      = gnt_r;
  assign busy     = busy_r;
  assign data_out = data_r;
  assign timeout  = timeout_r;

endmodule
